// File: rtl/mc_control_unit_v2.sv
// Main controller for the multi-cycle MIPS datapath: Moore sequencing FSM plus ALU decoder,
// with a memory ready handshake, a bounded wait-state timeout and illegal-instruction trapping.
module mc_control_unit_v2 #(
  parameter bit          MEM_HANDSHAKE = 1'b1,
  parameter int unsigned TIMEOUT_W     = 8,
  parameter int unsigned TIMEOUT_MAX   = 255,
  parameter bit          HALT_ON_TRAP  = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  input  logic       i_mem_ready,
  output logic       o_mem_req,
  output logic       o_pc_write,
  output logic [1:0] o_pc_src,
  output logic       o_branch,
  output logic       o_branch_ne,
  output logic       o_mem_write,
  output logic       o_mem_to_reg,
  output logic       o_reg_dst,
  output logic       o_reg_write,
  output logic       o_iord,
  output logic       o_ir_write,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [2:0] o_alu_control,
  output logic       o_illegal_instr,
  output logic       o_mem_timeout,
  output logic [3:0] o_state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC      = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_ADDI_EXEC = 4'd9,
    S_ADDI_WB   = 4'd10,
    S_JUMP      = 4'd11,
    S_TRAP      = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // A limit the counter cannot represent would never be reached, so treat it as disabled.
  localparam bit L_TO_EN = (TIMEOUT_MAX != 0) && (TIMEOUT_MAX <= (2 ** TIMEOUT_W) - 1);
  localparam logic [TIMEOUT_W-1:0] L_TMAX = TIMEOUT_W'(TIMEOUT_MAX);

  state_t               r_state;
  logic [5:0]           r_opcode;
  logic [TIMEOUT_W-1:0] r_wait_cnt;
  logic                 r_illegal;
  logic                 r_timeout;

  logic                 w_rdy;
  logic                 w_mem_state;
  logic                 w_funct_ok;
  logic                 w_wait_trap;
  logic [TIMEOUT_W-1:0] w_cnt_inc;
  logic [1:0]           w_alu_op;
  logic [2:0]           w_alu_ctl;

  assign w_rdy       = MEM_HANDSHAKE ? i_mem_ready : 1'b1;
  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_READ) ||
                       (r_state == S_MEM_WRITE);
  assign w_cnt_inc   = (&r_wait_cnt) ? r_wait_cnt : r_wait_cnt + TIMEOUT_W'(1);
  // A ready arriving on the limit cycle wins, so the trap needs rdy still low.
  assign w_wait_trap = L_TO_EN && w_mem_state && !w_rdy && (w_cnt_inc == L_TMAX);

  always_comb begin
    w_funct_ok = 1'b0;
    case (i_funct)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: w_funct_ok = 1'b1;
      default:                               w_funct_ok = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_FETCH;
      r_opcode   <= 6'd0;
      r_wait_cnt <= '0;
      r_illegal  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_mem_state && !w_rdy) r_wait_cnt <= w_cnt_inc;
      else                       r_wait_cnt <= '0;
      if (w_wait_trap) r_timeout <= 1'b1;

      case (r_state)
        S_FETCH: begin
          if (w_wait_trap) r_state <= S_TRAP;
          else if (w_rdy)  r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_opcode <= i_opcode;
          case (i_opcode)
            OP_LW, OP_SW:   r_state <= S_MEM_ADR;
            OP_R:           r_state <= S_EXEC;
            OP_BEQ, OP_BNE: r_state <= S_BRANCH;
            OP_ADDI:        r_state <= S_ADDI_EXEC;
            OP_J:           r_state <= S_JUMP;
            default: begin
              r_state   <= S_TRAP;
              r_illegal <= 1'b1;
            end
          endcase
        end
        S_MEM_ADR: begin
          if (r_opcode == OP_SW) r_state <= S_MEM_WRITE;
          else                   r_state <= S_MEM_READ;
        end
        S_MEM_READ: begin
          if (w_wait_trap) r_state <= S_TRAP;
          else if (w_rdy)  r_state <= S_MEM_WB;
        end
        S_MEM_WRITE: begin
          if (w_wait_trap) r_state <= S_TRAP;
          else if (w_rdy)  r_state <= S_FETCH;
        end
        S_EXEC: begin
          if (w_funct_ok) begin
            r_state <= S_ALU_WB;
          end else begin
            r_state   <= S_TRAP;
            r_illegal <= 1'b1;
          end
        end
        S_ADDI_EXEC: r_state <= S_ADDI_WB;
        S_MEM_WB, S_ALU_WB, S_ADDI_WB, S_BRANCH, S_JUMP: r_state <= S_FETCH;
        S_TRAP: begin
          if (!HALT_ON_TRAP) r_state <= S_FETCH;
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Moore decode; reset forces every control low, including the ready-gated FETCH enables.
  always_comb begin
    w_alu_op     = 2'b00;
    o_mem_req    = 1'b0;
    o_pc_write   = 1'b0;
    o_pc_src     = 2'b00;
    o_branch     = 1'b0;
    o_branch_ne  = 1'b0;
    o_mem_write  = 1'b0;
    o_mem_to_reg = 1'b0;
    o_reg_dst    = 1'b0;
    o_reg_write  = 1'b0;
    o_iord       = 1'b0;
    o_ir_write   = 1'b0;
    o_alu_src_a  = 1'b0;
    o_alu_src_b  = 2'b00;
    if (!i_rst) begin
      case (r_state)
        S_FETCH: begin
          o_mem_req   = 1'b1;
          o_alu_src_b = 2'b01;
          o_ir_write  = w_rdy;
          o_pc_write  = w_rdy;
        end
        S_DECODE: o_alu_src_b = 2'b11;
        S_MEM_ADR, S_ADDI_EXEC: begin
          o_alu_src_a = 1'b1;
          o_alu_src_b = 2'b10;
        end
        S_MEM_READ: begin
          o_mem_req = 1'b1;
          o_iord    = 1'b1;
        end
        S_MEM_WRITE: begin
          o_mem_req   = 1'b1;
          o_iord      = 1'b1;
          o_mem_write = 1'b1;
        end
        S_MEM_WB: begin
          o_reg_write  = 1'b1;
          o_mem_to_reg = 1'b1;
        end
        S_EXEC: begin
          o_alu_src_a = 1'b1;
          w_alu_op    = 2'b10;
        end
        S_ALU_WB: begin
          o_reg_write = 1'b1;
          o_reg_dst   = 1'b1;
        end
        S_ADDI_WB: o_reg_write = 1'b1;
        S_BRANCH: begin
          o_alu_src_a = 1'b1;
          w_alu_op    = 2'b01;
          o_pc_src    = 2'b01;
          o_branch    = (r_opcode == OP_BEQ);
          o_branch_ne = (r_opcode == OP_BNE);
        end
        S_JUMP: begin
          o_pc_src   = 2'b10;
          o_pc_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_alu_ctl = ALU_ADD;
    case (w_alu_op)
      2'b01: w_alu_ctl = ALU_SUB;
      2'b10: begin
        case (i_funct)
          FN_SUB:  w_alu_ctl = ALU_SUB;
          FN_AND:  w_alu_ctl = ALU_AND;
          FN_OR:   w_alu_ctl = ALU_OR;
          FN_SLT:  w_alu_ctl = ALU_SLT;
          default: w_alu_ctl = ALU_ADD;
        endcase
      end
      default: w_alu_ctl = ALU_ADD;
    endcase
  end

  assign o_alu_control   = (i_rst || (r_state == S_TRAP)) ? 3'b000 : w_alu_ctl;
  assign o_illegal_instr = r_illegal & ~i_rst;
  assign o_mem_timeout   = r_timeout & ~i_rst;
  assign o_state         = i_rst ? 4'd0 : r_state;

endmodule

// File: doc/mc_control_unit_v2.md
Name: mc_control_unit_v2

Overview:
Second-generation main controller for the multi-cycle MIPS datapath: a Moore FSM plus ALU decoder. It adds bne and j support to the add/sub/and/or/slt, lw/sw, beq and addi set. It adds a memory request/ready handshake with wait states and a bounded wait-timeout counter. Illegal-instruction and timeout trapping are also new. It sits between the instruction register (opcode/funct) and the datapath mux/enable controls.

Parameters:
MEM_HANDSHAKE, 1, 1: FETCH/MEM_READ/MEM_WRITE hold until mem_ready; 0: mem_ready ignored, these states last 1 cycle
TIMEOUT_W, 8, width of wait counter
TIMEOUT_MAX, 255, wait cycles tolerated before trap; 0 disables timeout
HALT_ON_TRAP, 1, 1: TRAP is terminal until reset; 0: TRAP returns to FETCH next cycle

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
opcode  in  6  instr[31:26]
funct  in  6  instr[5:0]
mem_ready  in  1  memory completed the current access
mem_req  out  1  memory access request
pc_write  out  1  unconditional PC enable
pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target
branch  out  1  beq: PC enable if zero
branch_ne  out  1  bne: PC enable if not zero
mem_write  out  1  memory write
mem_to_reg  out  1  writeback source is memory data
reg_dst  out  1  1 = rd, 0 = rt
reg_write  out  1  register file write
IorD  out  1  1 = data address (ALUOut)
ir_write  out  1  IR enable
alu_src_A  out  1  0 = PC, 1 = A
alu_src_B  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
alu_control  out  3  AND 000, OR 001, ADD 010, SUB 110, SLT 111
illegal_instr  out  1  sticky; set when entering TRAP on a bad opcode/funct
mem_timeout  out  1  sticky; set when entering TRAP on timeout
state_o  out  4  current state encoding (debug)

Behaviour:
- States and encodings: FETCH 0, DECODE 1, MEM_ADR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXEC 6, ALU_WB 7, BRANCH 8, ADDI_EXEC 9, ADDI_WB 10, JUMP 11, TRAP 12.
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, j 000010.
- Funct codes: add 100000, sub 100010, and 100100, or 100101, slt 101010.
- Outputs are a function of state only, except that the handshake gating uses mem_ready. Every output not listed for a state is 0.
- FETCH: mem_req=1, IorD=0, alu_src_A=0, alu_src_B=01, alu_op=00, pc_src=00. ir_write and pc_write equal rdy, where rdy = mem_ready if MEM_HANDSHAKE else 1.
- DECODE: alu_src_A=0, alu_src_B=11, alu_op=00.
- MEM_ADR and ADDI_EXEC: alu_src_A=1, alu_src_B=10, alu_op=00.
- MEM_READ: mem_req=1, IorD=1.
- MEM_WRITE: mem_req=1, IorD=1, mem_write=1. All three hold until rdy.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0.
- EXEC: alu_src_A=1, alu_src_B=00, alu_op=10.
- ALU_WB: reg_write=1, reg_dst=1.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0.
- BRANCH: alu_src_A=1, alu_src_B=00, alu_op=01, pc_src=01. branch=1 when the latched opcode is beq; branch_ne=1 when it is bne.
- JUMP: pc_src=10, pc_write=1.
- TRAP: all controls 0.
- Transitions:
  - FETCH->DECODE on rdy.
  - DECODE dispatches: lw/sw->MEM_ADR, R->EXEC, beq/bne->BRANCH, addi->ADDI_EXEC, j->JUMP, any other opcode->TRAP.
  - MEM_ADR: lw->MEM_READ, sw->MEM_WRITE.
  - MEM_READ->MEM_WB on rdy.
  - MEM_WRITE->FETCH on rdy.
  - EXEC->ALU_WB, or ->TRAP if funct is unsupported.
  - ADDI_EXEC->ADDI_WB.
  - MEM_WB, ALU_WB, ADDI_WB, BRANCH and JUMP each ->FETCH.
  - TRAP stays in TRAP if HALT_ON_TRAP, else ->FETCH.
- The opcode is latched on DECODE exit. Later states use the latched copy, because the IR is stable only while ir_write=0.
- ALU decoder: alu_op 00->ADD, 01->SUB, 10->by funct. Unsupported funct -> ADD, with the EXEC->TRAP path taken.
- Wait counter:
  - Cleared on entry to any memory state; increments each cycle in that state while rdy=0.
  - If TIMEOUT_MAX≠0 and the counter reaches TIMEOUT_MAX with rdy still 0: next state is TRAP and mem_timeout is set.
  - The counter saturates and never wraps.
  - A mem_ready arriving on the same cycle the limit is reached wins: normal advance, no trap.
- Reset:
  - While rst=1, all outputs are 0, including mem_req and the combinational FETCH outputs.
  - On the next edge: state=FETCH, counter=0, illegal_instr=0, mem_timeout=0, latched opcode=0.
  - Reset mid-access abandons the access; no write completes after reset.
- Latency per instruction with zero wait states: lw 5, sw 4, R 4, addi 4, beq/bne 3, j 3. Each mem wait cycle adds 1.

Test Plan:
- Reset, then R-type add (000000/100000) with mem_ready=1 -> states 0,1,6,7,0. alu_control=010 in EXEC; reg_write=1 and reg_dst=1 in ALU_WB.
- lw with mem_ready low 3 cycles in both FETCH and MEM_READ -> 11 cycles total. ir_write/pc_write high only on the ready cycle; mem_req held high throughout.
- bne (000101) -> BRANCH with branch_ne=1, branch=0, alu_control=110, pc_src=01. Then j -> JUMP with pc_write=1 and pc_src=10.
- Opcode 111111 -> TRAP with illegal_instr=1. With HALT_ON_TRAP=1 it stays in TRAP for 20 cycles; rst returns it to FETCH with the flag cleared.
- TIMEOUT_MAX=4, sw with mem_ready held 0 -> TRAP after 4 wait cycles with mem_timeout=1. Repeat with mem_ready rising on the 4th cycle -> no trap.
- rst asserted for 1 cycle during MEM_WRITE -> all outputs 0 that cycle, then state=FETCH and mem_write never reasserts for the aborted store.
